corre_window_sched: RTL
=======================

CORRE_WINDOW_SCHED -- requirements
Module: corre_window_sched

Interface
REQ-001 Parameter NREQ, default 3: number of correlator requesters (page, inquiry, connection).
REQ-002 Parameter CNT_W, default 10: width of the microsecond counters.
REQ-003 clk_6M  input  1  system clock, 6 MHz.
REQ-004 rstz  input  1  reset, asynchronous, active-low.
REQ-005 p_1us  input  1  one-clk strobe every 1 us.
REQ-006 ms_tslot_p  input  1  one-clk slot-start strobe.
REQ-007 req  input  NREQ  per-requester level: search wanted.
REQ-008 req_sync  input  NREQ*64  per-requester reference sync word; lane k = bits [64k+63:64k].
REQ-009 regi_winofs  input  CNT_W  window start offset after slot start, in us.
REQ-010 regi_winlen  input  CNT_W  window length, in us; 0 = disabled.
REQ-011 pscorr_trgp  input  1  correlator hit pulse.
REQ-012 correWindow  output  1  correlator search enable.
REQ-013 ref_sync  output  64  sync word of the granted requester.
REQ-014 grant  output  NREQ  one-hot grant.
REQ-015 hit_p  output  1  one-clk pulse: hit inside the window.
REQ-016 miss_p  output  1  one-clk pulse: window expired without a hit.

Function
REQ-017 FSM states: IDLE, WAIT_OFS, SEARCH, HOLD.
REQ-018 IDLE: on ms_tslot_p with any req set, arbitrate, register grant, clear us counter, go to WAIT_OFS; with no req, stay in IDLE.
REQ-019 ref_sync is registered from the granted lane in the same cycle as grant; it holds until the next grant; 0 while grant is 0.
REQ-020 WAIT_OFS: the counter increments on p_1us; when count reaches regi_winofs on p_1us, clear the counter, raise correWindow, go to SEARCH.
REQ-021 SEARCH: the counter increments on p_1us; pscorr_trgp -> hit_p next clk, drop correWindow, go to HOLD.
REQ-022 SEARCH: count reaching regi_winlen-1 on p_1us -> miss_p, drop correWindow, go to IDLE, clear grant.
REQ-023 pscorr_trgp and timeout in the same clk: hit wins; no miss_p.
REQ-024 pscorr_trgp outside SEARCH is ignored.
REQ-025 HOLD: keep grant until the next ms_tslot_p, then re-arbitrate exactly as from IDLE in that same clk.
REQ-026 ms_tslot_p in WAIT_OFS or SEARCH: miss_p, drop correWindow, re-arbitrate in that same clk.
REQ-027 Granted req deasserting in any non-IDLE state: drop correWindow and grant next clk, go to IDLE; no hit_p or miss_p.
REQ-028 regi_winlen == 0: correWindow never rises; miss_p on the clk the offset is reached; go to IDLE.
REQ-029 Counters saturate at all-ones and never wrap.
REQ-030 Register changes take effect at the next arbitration only; values are latched at grant.

Reset
REQ-031 Asynchronous reset: state IDLE, counter 0, grant 0, ref_sync 0, correWindow 0, hit_p 0, miss_p 0, round-robin pointer 0.
REQ-032 rstz asserted mid-SEARCH drops correWindow immediately; no pulses are emitted.

Configuration
REQ-033 Macro CORRE_SCHED_RR_EN defined: round-robin arbitration; the pointer advances to the granted index+1 (mod NREQ) on every grant.
REQ-034 CORRE_SCHED_RR_EN undefined: fixed priority, lowest index wins; no pointer register is present.

Structure
REQ-035 Shared package btbd_corre_pkg holds the FSM state enum, SLOT_US=625, and the SYNC_W=64 constant.
REQ-036 One sub-module, corre_arb: NREQ-wide fixed-priority/round-robin arbiter, combinational grant plus the pointer register.

Verification
REQ-037 Test 1: req=001, winofs=10, winlen=20, no hit -> correWindow high 20 us starting 10 us after ms_tslot_p; miss_p once; grant cleared.
REQ-038 Test 2: same setup, pscorr_trgp 5 us into the window -> hit_p once; correWindow falls next clk; grant held until the next ms_tslot_p.
REQ-039 Test 3: req=111 over 4 slots with all misses -> grant sequence 001,010,100,001 with RR_EN; 001 every slot without it.
REQ-040 Test 4: pscorr_trgp coincident with the final-us p_1us -> hit_p=1, miss_p=0.
REQ-041 Test 5: winlen=0 -> correWindow stays 0; miss_p at offset 10 us.
REQ-042 Test 6: rstz low mid-SEARCH -> all outputs 0 asynchronously; after release, IDLE until the next ms_tslot_p.

Source files
------------

// File: rtl/btbd_corre_pkg.sv
// Shared types and constants for the correlator window scheduler.
package btbd_corre_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OFS = 2'd1,
        SEARCH   = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam int SLOT_US = 625;
    localparam int SYNC_W  = 64;

endpackage

// File: rtl/corre_arb.sv
// Requester arbiter for the correlator scheduler.
// CORRE_SCHED_RR_EN defined  : round-robin, pointer moves to granted index+1.
// CORRE_SCHED_RR_EN undefined: fixed priority, lowest index wins, no state.
module corre_arb #(
    parameter int NREQ = 3
) (
`ifdef CORRE_SCHED_RR_EN
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic            adv,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

`ifdef CORRE_SCHED_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    // Scan from the far end back to ptr so the requester nearest ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        ptr_nxt = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                ptr_nxt  = PW'((idx + 1) % NREQ);
            end
        end
    end

    // Pointer only moves when the scheduler actually loads a grant.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr_nxt;
        end
    end
`else
    // Isolate the lowest set request bit.
    assign gnt = req & (~req + NREQ'(1));
`endif

endmodule

// File: rtl/corre_window_sched.sv
// Correlator search-window scheduler: arbitrates requesters at slot start,
// waits the offset, opens the search window, reports hit or miss.
// Optional build macro: CORRE_SCHED_RR_EN (round-robin arbitration).
module corre_window_sched
    import btbd_corre_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 10
) (
    input  logic                   clk_6M,
    input  logic                   rstz,
    input  logic                   p_1us,
    input  logic                   ms_tslot_p,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SYNC_W-1:0] req_sync,
    input  logic [CNT_W-1:0]       regi_winofs,
    input  logic [CNT_W-1:0]       regi_winlen,
    input  logic                   pscorr_trgp,
    output logic                   correWindow,
    output logic [SYNC_W-1:0]      ref_sync,
    output logic [NREQ-1:0]        grant,
    output logic                   hit_p,
    output logic                   miss_p
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [CNT_W-1:0]   ofs_l, ofs_n, len_l, len_n;
    logic [NREQ-1:0]    grant_n, arb_gnt;
    logic [SYNC_W-1:0]  sync_n, arb_sync;
    logic               win_n, hit_n, miss_n;
    logic               req_lost, rearb, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef CORRE_SCHED_RR_EN
    logic adv;
    assign adv = rearb && (|req);

    corre_arb #(.NREQ(NREQ)) u_arb (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .adv    (adv),
        .req    (req),
        .gnt    (arb_gnt)
    );
`else
    corre_arb #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .gnt    (arb_gnt)
    );
`endif

    // Sync word of the lane the arbiter would grant this cycle.
    always_comb begin
        arb_sync = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) arb_sync = req_sync[k*SYNC_W +: SYNC_W];
        end
    end

    assign cnt_inc  = sat_inc(cnt);
    assign req_lost = (state != IDLE) && ((grant & req) == '0);

    // Next-state logic; drop and rearb are applied after the per-state decision.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ofs_n   = ofs_l;
        len_n   = len_l;
        grant_n = grant;
        sync_n  = ref_sync;
        win_n   = correWindow;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        rearb   = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                rearb = ms_tslot_p;
            end
            WAIT_OFS: begin
                if (req_lost) begin
                    drop = 1'b1;
                end else if (ms_tslot_p) begin
                    miss_n = 1'b1;
                    rearb  = 1'b1;
                end else if (p_1us) begin
                    if (cnt_inc >= ofs_l) begin
                        cnt_n = '0;
                        if (len_l == '0) begin
                            miss_n = 1'b1;
                            drop   = 1'b1;
                        end else begin
                            win_n   = 1'b1;
                            state_n = SEARCH;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            SEARCH: begin
                if (req_lost) begin
                    drop = 1'b1;
                end else if (pscorr_trgp) begin
                    hit_n   = 1'b1;
                    win_n   = 1'b0;
                    state_n = HOLD;
                end else if (ms_tslot_p) begin
                    miss_n = 1'b1;
                    win_n  = 1'b0;
                    rearb  = 1'b1;
                end else if (p_1us) begin
                    if (cnt == len_l - CNT_W'(1)) begin
                        miss_n = 1'b1;
                        drop   = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (req_lost) drop = 1'b1;
                else          rearb = ms_tslot_p;
            end
            default: drop = 1'b1;
        endcase
        if (drop) begin
            state_n = IDLE;
            grant_n = '0;
            sync_n  = '0;
            win_n   = 1'b0;
        end
        if (rearb) begin
            if (|req) begin
                state_n = WAIT_OFS;
                grant_n = arb_gnt;
                sync_n  = arb_sync;
                cnt_n   = '0;
                ofs_n   = regi_winofs;
                len_n   = regi_winlen;
            end else begin
                state_n = IDLE;
                grant_n = '0;
                sync_n  = '0;
            end
        end
    end

    // State, counter, latched window registers and registered outputs.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state       <= IDLE;
            cnt         <= '0;
            ofs_l       <= '0;
            len_l       <= '0;
            grant       <= '0;
            ref_sync    <= '0;
            correWindow <= 1'b0;
            hit_p       <= 1'b0;
            miss_p      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ofs_l       <= ofs_n;
            len_l       <= len_n;
            grant       <= grant_n;
            ref_sync    <= sync_n;
            correWindow <= win_n;
            hit_p       <= hit_n;
            miss_p      <= miss_n;
        end
    end

endmodule
